// File: rtl/decode_alu_pipe_pkg.sv
// Shared types for the RV32 ALU decode stage: ALU operation codes, opcode and
// funct7 constants, the decoded-entry struct and the funct3 lookup helpers.
package decode_alu_pipe_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17,
        ALU_NOP    = 5'd31
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    // Immediate is held at 32 bits; the top sign-extends it to XLEN on output.
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        alu_ctrl_e   alu_ctrl;
        logic        illegal;
    } decoded_t;

    localparam decoded_t ENTRY_RESET = '{
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0,
        use_imm: 1'b0, alu_ctrl: ALU_NOP, illegal: 1'b0
    };

    // Illegal instructions carry no operand information downstream.
    localparam decoded_t ENTRY_ILLEGAL = '{
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0,
        use_imm: 1'b0, alu_ctrl: ALU_NOP, illegal: 1'b1
    };

    // Base integer funct3 map shared by OP and OP-IMM.
    function automatic alu_ctrl_e base_alu(input logic [2:0] funct3);
        alu_ctrl_e op;
        case (funct3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // M-extension funct3 map.
    function automatic alu_ctrl_e muldiv_alu(input logic [2:0] funct3);
        alu_ctrl_e op;
        case (funct3)
            3'd0:    op = ALU_MUL;
            3'd1:    op = ALU_MULH;
            3'd2:    op = ALU_MULHSU;
            3'd3:    op = ALU_MULHU;
            3'd4:    op = ALU_DIV;
            3'd5:    op = ALU_DIVU;
            3'd6:    op = ALU_REM;
            default: op = ALU_REMU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_alu_pipe_if.sv
// Instruction-in / decoded-out handshake bundle for the ALU decode stage.
// master: the surrounding pipeline (fetch side drives, execute side accepts).
// slave:  the decode stage itself.
interface decode_alu_pipe_if
    import decode_alu_pipe_pkg::*;
#(
    parameter int XLEN = 32
);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;

    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_use_imm;
    alu_ctrl_e       out_alu_ctrl;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_alu_ctrl, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_rs1, out_rs2, out_rd,
               out_imm, out_use_imm, out_alu_ctrl, out_illegal
    );

endinterface

// File: rtl/decode_alu_comb.sv
// Pure combinational RV32 OP / OP-IMM decoder: instruction word -> decoded_t.
module decode_alu_comb
    import decode_alu_pipe_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    decoded_t raw;
    logic     legal;

    // Field extraction and legality check per opcode/funct3/funct7.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        raw   = ENTRY_RESET;
        legal = 1'b0;

        case (opcode)
            OPC_OP: begin
                raw.rs1 = rs1;
                raw.rs2 = rs2;
                raw.rd  = rd;
                case (funct7)
                    F7_BASE: begin
                        raw.alu_ctrl = base_alu(funct3);
                        legal        = 1'b1;
                    end
                    F7_ALT: begin
                        if (funct3 == 3'd0) begin
                            raw.alu_ctrl = ALU_SUB;
                            legal        = 1'b1;
                        end else if (funct3 == 3'd5) begin
                            raw.alu_ctrl = ALU_SRA;
                            legal        = 1'b1;
                        end
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M) begin
                            raw.alu_ctrl = muldiv_alu(funct3);
                            legal        = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            OPC_OP_IMM: begin
                raw.rs1     = rs1;
                raw.rd      = rd;
                raw.use_imm = 1'b1;
                raw.imm     = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    3'd1: begin
                        raw.imm = {27'd0, rs2};
                        if (funct7 == F7_BASE) begin
                            raw.alu_ctrl = ALU_SLL;
                            legal        = 1'b1;
                        end
                    end
                    3'd5: begin
                        raw.imm = {27'd0, rs2};
                        if (funct7 == F7_BASE) begin
                            raw.alu_ctrl = ALU_SRL;
                            legal        = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            raw.alu_ctrl = ALU_SRA;
                            legal        = 1'b1;
                        end
                    end
                    default: begin
                        raw.alu_ctrl = base_alu(funct3);
                        legal        = 1'b1;
                    end
                endcase
            end

            default: ;
        endcase

        dec = legal ? raw : ENTRY_ILLEGAL;
    end

endmodule

// File: rtl/decode_alu_pipe.sv
// Registered ALU decode stage: main output register plus one skid register,
// synchronous flush, and saturating accepted/illegal instruction counters.
module decode_alu_pipe
    import decode_alu_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    decode_alu_pipe_if.slave bus,
    output logic [CNT_W-1:0] cnt_decoded,
    output logic [CNT_W-1:0] cnt_illegal
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    decoded_t dec;
    decoded_t main_q;
    decoded_t skid_q;
    logic     main_valid;
    logic     skid_valid;
    logic     accept;
    logic     pop;

    decode_alu_comb #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr (bus.in_instr),
        .dec   (dec)
    );

    // The skid register only fills while main is stalled, so a full skid is
    // exactly the condition for back-pressure upstream.
    assign bus.in_ready = rst_n && !skid_valid;
    assign accept       = bus.in_valid && bus.in_ready && !flush;
    assign pop          = main_valid && bus.out_ready;

    // Main/skid occupancy and payload; main refills from skid first to keep order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            // NOTE: payload registers are reset too, because out_* fields are
            // driven straight from main_q and must read as zero/NOP after reset.
            main_q     <= ENTRY_RESET;
            skid_q     <= ENTRY_RESET;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || pop) begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= dec;
                end
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    // Saturating performance counters; flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_decoded <= '0;
            cnt_illegal <= '0;
        end else if (accept) begin
            if (cnt_decoded != CNT_MAX) begin
                cnt_decoded <= cnt_decoded + CNT_W'(1);
            end
            if (dec.illegal && (cnt_illegal != CNT_MAX)) begin
                cnt_illegal <= cnt_illegal + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid    = main_valid;
    assign bus.out_rs1      = main_q.rs1;
    assign bus.out_rs2      = main_q.rs2;
    assign bus.out_rd       = main_q.rd;
    assign bus.out_imm      = XLEN'($signed(main_q.imm));
    assign bus.out_use_imm  = main_q.use_imm;
    assign bus.out_alu_ctrl = main_q.alu_ctrl;
    assign bus.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_decode_alu_pipe.sv
// Directed bench for decode_alu_pipe. dut0: ENABLE_M=0, CNT_W=4.
// dutm: ENABLE_M=1, CNT_W=16, driven in lockstep with dut0.
module tb_decode_alu_pipe;
    import decode_alu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [3:0]  cnt0_dec, cnt0_ill;
    logic [15:0] cntm_dec, cntm_ill;

    int n_vec  = 0;
    int n_miss = 0;

    decode_alu_pipe_if #(.XLEN(32)) bus0 ();
    decode_alu_pipe_if #(.XLEN(32)) busm ();

    assign busm.in_valid  = bus0.in_valid;
    assign busm.in_instr  = bus0.in_instr;
    assign busm.out_ready = bus0.out_ready;

    decode_alu_pipe #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0),
        .cnt_decoded(cnt0_dec), .cnt_illegal(cnt0_ill)
    );

    decode_alu_pipe #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(16)) dutm (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(busm),
        .cnt_decoded(cntm_dec), .cnt_illegal(cntm_ill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        alu_ctrl_e   alu;
        logic        illegal;
        alu_ctrl_e   alu_m;
        logic        ill_m;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string tag, input int k);
        check({tag, ".valid"},   64'(bus0.out_valid),    64'd1);
        check({tag, ".rs1"},     64'(bus0.out_rs1),      64'(vecs[k].rs1));
        check({tag, ".rs2"},     64'(bus0.out_rs2),      64'(vecs[k].rs2));
        check({tag, ".rd"},      64'(bus0.out_rd),       64'(vecs[k].rd));
        check({tag, ".imm"},     64'(bus0.out_imm),      64'(vecs[k].imm));
        check({tag, ".use_imm"}, 64'(bus0.out_use_imm), 64'(vecs[k].use_imm));
        check({tag, ".alu"},     64'(bus0.out_alu_ctrl), 64'(vecs[k].alu));
        check({tag, ".illegal"}, 64'(bus0.out_illegal), 64'(vecs[k].illegal));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           instr         rs1    rs2    rd     imm           ui    alu       ill   alu_m     ill_m
        vecs[0]  = '{32'h002081B3, 5'd1,  5'd2,  5'd3,  32'h0,        1'b0, ALU_ADD,  1'b0, ALU_ADD,  1'b0}; // ADD x3,x1,x2
        vecs[1]  = '{32'hFFF00293, 5'd0,  5'd0,  5'd5,  32'hFFFFFFFF, 1'b1, ALU_ADD,  1'b0, ALU_ADD,  1'b0}; // ADDI x5,x0,-1
        vecs[2]  = '{32'h4043D313, 5'd7,  5'd0,  5'd6,  32'h4,        1'b1, ALU_SRA,  1'b0, ALU_SRA,  1'b0}; // SRAI x6,x7,4
        vecs[3]  = '{32'h022081B3, 5'd0,  5'd0,  5'd0,  32'h0,        1'b0, ALU_NOP,  1'b1, ALU_MUL,  1'b0}; // MUL x3,x1,x2
        vecs[4]  = '{32'h402081B3, 5'd1,  5'd2,  5'd3,  32'h0,        1'b0, ALU_SUB,  1'b0, ALU_SUB,  1'b0}; // SUB x3,x1,x2
        vecs[5]  = '{32'h0000007F, 5'd0,  5'd0,  5'd0,  32'h0,        1'b0, ALU_NOP,  1'b1, ALU_NOP,  1'b1}; // bad opcode
        vecs[6]  = '{32'h40209193, 5'd0,  5'd0,  5'd0,  32'h0,        1'b0, ALU_NOP,  1'b1, ALU_NOP,  1'b1}; // SLLI with f7=0x20
        vecs[7]  = '{32'h00209193, 5'd1,  5'd0,  5'd3,  32'h2,        1'b1, ALU_SLL,  1'b0, ALU_SLL,  1'b0}; // SLLI x3,x1,2
        vecs[8]  = '{32'h7FF17213, 5'd2,  5'd0,  5'd4,  32'h7FF,      1'b1, ALU_AND,  1'b0, ALU_AND,  1'b0}; // ANDI x4,x2,0x7FF
        vecs[9]  = '{32'h00C5B533, 5'd11, 5'd12, 5'd10, 32'h0,        1'b0, ALU_SLTU, 1'b0, ALU_SLTU, 1'b0}; // SLTU x10,x11,x12
        vecs[10] = '{32'h402091B3, 5'd0,  5'd0,  5'd0,  32'h0,        1'b0, ALU_NOP,  1'b1, ALU_NOP,  1'b1}; // f7=0x20 f3=1
        vecs[11] = '{32'h0043D313, 5'd7,  5'd0,  5'd6,  32'h4,        1'b1, ALU_SRL,  1'b0, ALU_SRL,  1'b0}; // SRLI x6,x7,4

        rst_n          = 1'b0;
        flush          = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_instr  = 32'h0;
        bus0.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst.in_ready", 64'(bus0.in_ready), 64'd0);
        step();
        step();
        check("rst.out_valid", 64'(bus0.out_valid),    64'd0);
        check("rst.alu",       64'(bus0.out_alu_ctrl), 64'(ALU_NOP));
        check("rst.rd",        64'(bus0.out_rd),       64'd0);
        check("rst.imm",       64'(bus0.out_imm),      64'd0);
        check("rst.illegal",   64'(bus0.out_illegal),  64'd0);
        check("rst.cnt_dec",   64'(cnt0_dec),          64'd0);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready_rel", 64'(bus0.in_ready), 64'd1);

        // Decode table, back-to-back at one instruction per cycle
        for (int i = 0; i < 12; i++) begin
            bus0.in_valid = 1'b1;
            bus0.in_instr = vecs[i].instr;
            step();
            check_entry($sformatf("v%0d", i), i);
            check($sformatf("v%0d.m_alu", i),     64'(busm.out_alu_ctrl), 64'(vecs[i].alu_m));
            check($sformatf("v%0d.m_illegal", i), 64'(busm.out_illegal),  64'(vecs[i].ill_m));
        end
        bus0.in_valid = 1'b0;
        step();
        check("tbl.drain_valid", 64'(bus0.out_valid), 64'd0);
        check("tbl.cnt0_dec",    64'(cnt0_dec),       64'd12);
        check("tbl.cnt0_ill",    64'(cnt0_ill),       64'd4);
        check("tbl.cntm_dec",    64'(cntm_dec),       64'd12);
        check("tbl.cntm_ill",    64'(cntm_ill),       64'd3);

        // Flush with main and skid full and a valid input present
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.in_instr  = vecs[0].instr;
        step();
        bus0.in_instr  = vecs[1].instr;
        step();
        check("fl.full_in_ready", 64'(bus0.in_ready), 64'd0);
        check("fl.cnt_before",    64'(cnt0_dec),      64'd14);
        bus0.in_instr = vecs[2].instr;
        flush = 1'b1;
        step();
        check("fl.out_valid", 64'(bus0.out_valid), 64'd0);
        check("fl.in_ready",  64'(bus0.in_ready),  64'd1);
        check("fl.cnt_dec",   64'(cnt0_dec),       64'd14);
        step();  // flush held while in_ready=1: input must be dropped
        check("fl.drop_valid", 64'(bus0.out_valid), 64'd0);
        check("fl.drop_cnt",   64'(cnt0_dec),       64'd14);
        check("fl.drop_cntm",  64'(cntm_dec),       64'd14);
        flush = 1'b0;
        bus0.in_valid = 1'b0;
        step();
        check("fl.after_valid", 64'(bus0.out_valid), 64'd0);

        // Stream four instructions with out_ready low for three cycles
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b1;
        bus0.in_instr  = vecs[0].instr;
        step();
        check_entry("st0", 0);
        check("st0.in_ready", 64'(bus0.in_ready), 64'd1);
        bus0.in_instr = vecs[1].instr;
        step();
        check_entry("st1", 0);
        check("st1.in_ready", 64'(bus0.in_ready), 64'd0);
        bus0.in_instr = vecs[2].instr;
        step();
        check_entry("st2", 0);
        check("st2.in_ready", 64'(bus0.in_ready), 64'd0);
        bus0.out_ready = 1'b1;
        step();
        check_entry("st3", 1);
        check("st3.in_ready", 64'(bus0.in_ready), 64'd1);
        step();
        check_entry("st4", 2);
        bus0.in_instr = vecs[4].instr;
        step();
        check_entry("st5", 4);
        bus0.in_valid = 1'b0;
        step();
        check("st6.out_valid", 64'(bus0.out_valid), 64'd0);
        check("st.cnt0_sat",   64'(cnt0_dec),       64'd15);
        check("st.cntm_dec",   64'(cntm_dec),       64'd18);

        // Saturation at 2^CNT_W-1, then asynchronous reset mid-stream
        bus0.in_valid = 1'b1;
        bus0.in_instr = vecs[0].instr;
        repeat (5) step();
        check("sat.cnt0_dec",  64'(cnt0_dec),       64'd15);
        check("sat.cnt0_ill",  64'(cnt0_ill),       64'd4);
        check("sat.cntm_dec",  64'(cntm_dec),       64'd23);
        check("sat.cntm_ill",  64'(cntm_ill),       64'd3);
        check("sat.out_valid", 64'(bus0.out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid",  64'(bus0.out_valid),  64'd0);
        check("arst.m_valid",    64'(busm.out_valid),  64'd0);
        check("arst.in_ready",   64'(bus0.in_ready),   64'd0);
        check("arst.cnt0_dec",   64'(cnt0_dec),        64'd0);
        check("arst.cntm_dec",   64'(cntm_dec),        64'd0);
        check("arst.alu",        64'(bus0.out_alu_ctrl), 64'(ALU_NOP));
        bus0.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("arst.rel_valid", 64'(bus0.out_valid), 64'd0);
        check("arst.rel_cnt",   64'(cnt0_dec),       64'd0);
        bus0.in_valid = 1'b1;
        bus0.in_instr = vecs[9].instr;
        step();
        check_entry("post", 9);
        check("post.cnt0_dec", 64'(cnt0_dec), 64'd1);
        bus0.in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
